// File: rtl/seg_adder_pipe.sv
// Pipelined segmented adder/subtractor. Operands are split into N_LIMB limbs;
// stage 0 adds every limb independently, then stage k ripples the carry of
// limb k-1 into limb k. Each transaction carries its own segment layout down
// the pipe, so segment width can change on every accepted input.
module seg_adder_pipe #(
   parameter int unsigned W_LIMB  = 32,
   parameter int unsigned N_LIMB  = 8,
   parameter int unsigned W_TOTAL = W_LIMB * N_LIMB,
   parameter int unsigned W_SEL   = $clog2($clog2(N_LIMB) + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [W_TOTAL-1:0] a_i,
   input  logic [W_TOTAL-1:0] b_i,
   input  logic               sub_i,
   input  logic [W_SEL-1:0]   seg_sel_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [W_TOTAL-1:0] sum_o,
   output logic [N_LIMB-1:0]  cout_o
);

   // Bit j set when limb j opens a segment of 2**seg limbs. An oversized seg
   // gives a mask covering every limb index, so only limb 0 starts a segment,
   // which is exactly the clamp to a full-width segment.
   function automatic logic [N_LIMB-1:0] start_of(input logic [W_SEL-1:0] seg);
      logic [N_LIMB-1:0] v;
      logic [31:0]       m;
      m = (32'd1 << seg) - 32'd1;
      for (int j = 0; j < N_LIMB; j++) begin
         v[j] = ((32'(j) & m) == 32'd0);
      end
      return v;
   endfunction

   // Per-stage state: valid, limb data, sticky per-limb carries, segment starts
   logic                          vld_q  [N_LIMB];
   logic                          vld_d  [N_LIMB];
   logic [N_LIMB-1:0][W_LIMB-1:0] limb_q [N_LIMB];
   logic [N_LIMB-1:0][W_LIMB-1:0] limb_d [N_LIMB];
   logic [N_LIMB-1:0]             cy_q   [N_LIMB];
   logic [N_LIMB-1:0]             cy_d   [N_LIMB];
   logic [N_LIMB-1:0]             st_q   [N_LIMB];
   logic [N_LIMB-1:0]             st_d   [N_LIMB];

   logic                          en;
   logic [N_LIMB-1:0]             st_in;
   logic [W_LIMB-1:0]             b_op;
   logic [W_LIMB:0]               sum0;
   logic [W_LIMB:0]               inc;

   assign en      = !vld_q[N_LIMB-1] | ready_i;
   assign ready_o = en;
   assign valid_o = vld_q[N_LIMB-1];
   assign sum_o   = limb_q[N_LIMB-1];
   // Limb k ends a segment when limb k+1 starts one; the top limb always ends one
   assign cout_o  = cy_q[N_LIMB-1] & {1'b1, st_q[N_LIMB-1][N_LIMB-1:1]};

   // Next-state for all stages: limb-parallel add in stage 0, one carry hop per later stage
   always_comb begin
      st_in = start_of(seg_sel_i);
      b_op  = '0;
      sum0  = '0;
      inc   = '0;

      // Bubbles enter as all-zero so an idle pipe shows sum_o=0, cout_o=0
      vld_d[0]  = valid_i;
      limb_d[0] = '0;
      cy_d[0]   = '0;
      st_d[0]   = '0;
      if (valid_i) begin
         st_d[0] = st_in;
         for (int j = 0; j < N_LIMB; j++) begin
            b_op = sub_i ? ~b_i[j*W_LIMB +: W_LIMB] : b_i[j*W_LIMB +: W_LIMB];
            // Two's-complement +1 is injected only at the segment's lowest limb
            sum0 = {1'b0, a_i[j*W_LIMB +: W_LIMB]} + {1'b0, b_op}
                   + {{W_LIMB{1'b0}}, sub_i & st_in[j]};
            limb_d[0][j] = sum0[W_LIMB-1:0];
            cy_d[0][j]   = sum0[W_LIMB];
         end
      end

      for (int k = 1; k < N_LIMB; k++) begin
         vld_d[k]  = vld_q[k-1];
         limb_d[k] = limb_q[k-1];
         cy_d[k]   = cy_q[k-1];
         st_d[k]   = st_q[k-1];
         if (!st_q[k-1][k]) begin
            // Carry of limb k-1 is final here: it was resolved by stage k-1
            inc = {1'b0, limb_q[k-1][k]} + {{W_LIMB{1'b0}}, cy_q[k-1][k-1]};
            limb_d[k][k] = inc[W_LIMB-1:0];
            cy_d[k][k]   = cy_q[k-1][k] | inc[W_LIMB];
         end
      end
   end

   // Stage registers: cleared on reset, all advance together when en, else hold
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < N_LIMB; k++) begin
            vld_q[k]  <= 1'b0;
            limb_q[k] <= '0;
            cy_q[k]   <= '0;
            st_q[k]   <= '0;
         end
      end else if (en) begin
         for (int k = 0; k < N_LIMB; k++) begin
            vld_q[k]  <= vld_d[k];
            limb_q[k] <= limb_d[k];
            cy_q[k]   <= cy_d[k];
            st_q[k]   <= st_d[k];
         end
      end
   end

endmodule

// File: tb/tb_seg_adder_pipe.sv
// Bench for seg_adder_pipe at W_LIMB=32, N_LIMB=8: directed corner cases,
// a random backpressured stream checked against a big-integer segment model,
// and a mid-flight reset.
module tb_seg_adder_pipe;

   localparam int W_LIMB = 32;
   localparam int N_LIMB = 8;
   localparam int W_TOT  = 256;

   logic              clk;
   logic              rst_i;
   logic              valid_i;
   logic              ready_o;
   logic [W_TOT-1:0]  a_i;
   logic [W_TOT-1:0]  b_i;
   logic              sub_i;
   logic [1:0]        seg_sel_i;
   logic              valid_o;
   logic              ready_i;
   logic [W_TOT-1:0]  sum_o;
   logic [N_LIMB-1:0] cout_o;

   int total = 0;
   int bad   = 0;

   seg_adder_pipe #(
      .W_LIMB (W_LIMB),
      .N_LIMB (N_LIMB)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .a_i       (a_i),
      .b_i       (b_i),
      .sub_i     (sub_i),
      .seg_sel_i (seg_sel_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .sum_o     (sum_o),
      .cout_o    (cout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [W_TOT-1:0] obs, input logic [W_TOT-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Each segment is treated as one unsigned integer of 32*2**sel bits.
   // sel is 2 bits wide here, so it can never exceed log2(8)=3.
   function automatic void ref_model(input logic [W_TOT-1:0] a, input logic [W_TOT-1:0] b,
                                      input logic sub, input logic [1:0] sel,
                                      output logic [W_TOT-1:0] s, output logic [N_LIMB-1:0] c);
      int          segl;
      int          sw;
      logic [W_TOT:0] m;
      logic [W_TOT:0] av;
      logic [W_TOT:0] bv;
      logic [W_TOT:0] r;
      segl = 1 << sel;
      sw   = segl * W_LIMB;
      m    = (257'd1 << sw) - 257'd1;
      s    = '0;
      c    = '0;
      for (int base = 0; base < N_LIMB; base += segl) begin
         av = ({1'b0, a} >> (base * W_LIMB)) & m;
         bv = ({1'b0, b} >> (base * W_LIMB)) & m;
         if (sub) begin
            r = (av - bv) & m;
            c[base+segl-1] = (av >= bv);
         end else begin
            r = av + bv;
            c[base+segl-1] = r[sw];
            r = r & m;
         end
         s = s | W_TOT'(r << (base * W_LIMB));
      end
   endfunction

   task automatic rand_op(output logic [W_TOT-1:0] v);
      for (int i = 0; i < N_LIMB; i++) begin
         // All-ones limbs are common so long carry ripples actually happen
         v[i*W_LIMB +: W_LIMB] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
   endtask

   // Single transaction with ready_i held high; called at posedge+1
   task automatic run_one(input string tag, input logic [W_TOT-1:0] a, input logic [W_TOT-1:0] b,
                          input logic sub, input logic [1:0] sel,
                          input logic [W_TOT-1:0] es, input logic [N_LIMB-1:0] ec);
      int n;
      valid_i = 1'b1; a_i = a; b_i = b; sub_i = sub; seg_sel_i = sel; ready_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0; a_i = '0; b_i = '0;
      n = 1;
      while (!valid_o && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, W_TOT'(n), W_TOT'(N_LIMB));
      chk({tag, " sum_o"}, sum_o, es);
      chk({tag, " cout_o"}, W_TOT'(cout_o), W_TOT'(ec));
      @(posedge clk); #1;
      chk({tag, " drained"}, W_TOT'(valid_o), W_TOT'(0));
   endtask

   logic [W_TOT-1:0]  ta, tb_b, es;
   logic [N_LIMB-1:0] ec;
   logic              tsub;
   logic [1:0]        tsel;
   logic [2:0]        wide_sel;
   logic [W_TOT-1:0]  exp_s_q [$];
   logic [N_LIMB-1:0] exp_c_q [$];
   logic [W_TOT-1:0]  held_s;
   logic [N_LIMB-1:0] held_c;
   logic              held, seen, noisy;
   int                sent, got, cyc;

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
      a_i = '0; b_i = '0; sub_i = 1'b0; seg_sel_i = '0;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      chk("reset valid_o", W_TOT'(valid_o), W_TOT'(0));
      chk("reset sum_o", sum_o, '0);
      chk("reset cout_o", W_TOT'(cout_o), W_TOT'(0));
      chk("reset ready_o", W_TOT'(ready_o), W_TOT'(1));

      // Full-width ripple through all eight limbs
      run_one("t1 256b", {W_TOT{1'b1}}, W_TOT'(1), 1'b0, 2'd3, '0, 8'h80);
      // 64-bit segments: carry must stop at every 64-bit boundary
      run_one("t2 64b", {W_TOT{1'b1}}, {4{64'h1}}, 1'b0, 2'd1, '0, 8'b1010_1010);
      // 32-bit segments, every limb borrows
      run_one("t3 32b sub", '0, {8{32'h1}}, 1'b1, 2'd0, {8{32'hFFFF_FFFF}}, 8'h00);
      // 7 does not fit the 2-bit port; its low bits select the full width
      wide_sel = 3'd7;
      run_one("t6 clamp", W_TOT'(1) << 255, W_TOT'(1) << 255, 1'b0, wide_sel[1:0], '0, 8'h80);

      // Random back-to-back stream with random downstream stalls
      rand_op(ta); rand_op(tb_b);
      tsub = 1'($urandom_range(0, 1)); tsel = 2'($urandom_range(0, 3));
      sent = 0; got = 0; cyc = 0; held = 1'b0;
      held_s = '0; held_c = '0;
      while ((sent < 16 || got < 16) && cyc < 400) begin
         valid_i = (sent < 16); a_i = ta; b_i = tb_b; sub_i = tsub; seg_sel_i = tsel;
         ready_i = ($urandom_range(0, 2) != 0);
         #1;
         if (held) begin
            chk("stall valid_o", W_TOT'(valid_o), W_TOT'(1));
            chk("stall sum_o", sum_o, held_s);
            chk("stall cout_o", W_TOT'(cout_o), W_TOT'(held_c));
         end
         if (valid_o && ready_i) begin
            chk("stream expected", W_TOT'(exp_s_q.size() > 0), W_TOT'(1));
            if (exp_s_q.size() > 0) begin
               chk("stream sum_o", sum_o, exp_s_q.pop_front());
               chk("stream cout_o", W_TOT'(cout_o), W_TOT'(exp_c_q.pop_front()));
            end
            got++;
         end
         held   = valid_o && !ready_i;
         held_s = sum_o;
         held_c = cout_o;
         if (valid_i && ready_o) begin
            ref_model(ta, tb_b, tsub, tsel, es, ec);
            exp_s_q.push_back(es);
            exp_c_q.push_back(ec);
            sent++;
            rand_op(ta); rand_op(tb_b);
            tsub = 1'($urandom_range(0, 1)); tsel = 2'($urandom_range(0, 3));
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("stream sent", W_TOT'(sent), W_TOT'(16));
      chk("stream got", W_TOT'(got), W_TOT'(16));
      valid_i = 1'b0; ready_i = 1'b1;
      repeat (N_LIMB + 2) @(posedge clk);
      #1;

      // Three transactions in flight, reset lands on the third
      rand_op(ta); rand_op(tb_b);
      valid_i = 1'b1; a_i = ta; b_i = tb_b; sub_i = 1'b0; seg_sel_i = 2'd0; ready_i = 1'b1;
      @(posedge clk); #1;
      a_i = ~ta;
      @(posedge clk); #1;
      a_i = ta ^ tb_b;
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0; valid_i = 1'b0;
      seen = 1'b0; noisy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (valid_o) seen = 1'b1;
         if (sum_o != '0 || cout_o != '0) noisy = 1'b1;
         @(posedge clk); #1;
      end
      chk("rst valid_o never", W_TOT'(seen), W_TOT'(0));
      chk("rst outputs quiet", W_TOT'(noisy), W_TOT'(0));
      chk("rst sum_o", sum_o, '0);
      chk("rst cout_o", W_TOT'(cout_o), W_TOT'(0));
      chk("rst ready_o", W_TOT'(ready_o), W_TOT'(1));

      rand_op(ta); rand_op(tb_b);
      ref_model(ta, tb_b, 1'b1, 2'd2, es, ec);
      run_one("post-rst 128b sub", ta, tb_b, 1'b1, 2'd2, es, ec);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
